vip_frame_stream_gen: RTL and testbench

//  Source end of the ISP video stream interface (vsync/href/clken/Y). Generates frame timing and
//  8-bit grey test patterns that drive filter/dehaze pipeline stages in place of the sensor/SD path.

---
 rtl/vip_frame_stream_gen.sv | 149 ++++++++++++++
 tb/tb_vip_frame_stream_gen.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/vip_frame_stream_gen.sv
// vip_frame_stream_gen
//   Test-pattern source for the ISP video stream interface. Produces vsync/href/clken
//   timing and an 8-bit grey pattern in place of the sensor path.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | stopped, outputs low, waiting for enable
//   ST_VSYNC  | V_SYNC lines with vsync high
//   ST_VBACK  | V_BACK blank lines before the active region
//   ST_ACTIVE | IMG_VDISP lines carrying href/clken/Y
//   ST_VFRONT | V_FRONT blank lines, frame_done on the last clk
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   enable              run request (level); a running frame always completes
//   pattern_sel[1:0]    0 H-ramp, 1 V-ramp, 2 8x8 checker, 3 flat frame_cnt[7:0]
//   post_frame_vsync    frame sync
//   post_frame_href     active-pixel line window
//   post_frame_clken    pixel strobe, Y valid when high
//   post_img_Y[7:0]     pixel value
//   frame_done          one-clk pulse on the last clk of each frame
//   frame_cnt[15:0]     completed-frame count
module vip_frame_stream_gen #(
    parameter logic [10:0] IMG_HDISP = 11'd1024,
    parameter logic [10:0] IMG_VDISP = 11'd768,
    parameter logic [10:0] H_BLANK   = 11'd64,
    parameter logic [10:0] V_SYNC    = 11'd2,
    parameter logic [10:0] V_BACK    = 11'd2,
    parameter logic [10:0] V_FRONT   = 11'd2,
    parameter logic [3:0]  CLKEN_DIV = 4'd1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  pattern_sel,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [7:0]  post_img_Y,
    output logic        frame_done,
    output logic [15:0] frame_cnt
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_VSYNC  = 3'd1;
    localparam logic [2:0] ST_VBACK  = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_VFRONT = 3'd4;

    localparam logic [11:0] X_ACT    = {1'b0, IMG_HDISP};
    localparam logic [11:0] X_LAST   = {1'b0, IMG_HDISP} + {1'b0, H_BLANK} - 12'd1;
    localparam logic [3:0]  DIV_LAST = CLKEN_DIV - 4'd1;

    logic [2:0]  state, state_nx;
    logic [3:0]  div_cnt, div_nx;
    logic [11:0] x_cnt, x_nx;
    logic [10:0] line_cnt, line_nx, line_last;
    logic [1:0]  pat_q;
    logic        vsync_nx, href_nx, clken_nx, done_nx;
    logic [7:0]  pix_nx;

    always_comb begin
        case (state)
            ST_VSYNC:  line_last = V_SYNC - 11'd1;
            ST_VBACK:  line_last = V_BACK - 11'd1;
            ST_ACTIVE: line_last = IMG_VDISP - 11'd1;
            default:   line_last = V_FRONT - 11'd1;
        endcase
    end

    // Next counter/state values; the outputs are registered from these so they
    // line up with the counters rather than lagging them by one clk.
    always_comb begin
        state_nx = state;
        div_nx   = div_cnt;
        x_nx     = x_cnt;
        line_nx  = line_cnt;
        if (state == ST_IDLE) begin
            div_nx  = 4'd0;
            x_nx    = 12'd0;
            line_nx = 11'd0;
            if (enable) state_nx = ST_VSYNC;
        end else if (div_cnt == DIV_LAST) begin
            div_nx = 4'd0;
            if (x_cnt == X_LAST) begin
                x_nx = 12'd0;
                if (line_cnt == line_last) begin
                    line_nx = 11'd0;
                    case (state)
                        ST_VSYNC:  state_nx = ST_VBACK;
                        ST_VBACK:  state_nx = ST_ACTIVE;
                        ST_ACTIVE: state_nx = ST_VFRONT;
                        default:   state_nx = enable ? ST_VSYNC : ST_IDLE;
                    endcase
                end else begin
                    line_nx = line_cnt + 11'd1;
                end
            end else begin
                x_nx = x_cnt + 12'd1;
            end
        end else begin
            div_nx = div_cnt + 4'd1;
        end
    end

    always_comb begin
        vsync_nx = (state_nx == ST_VSYNC);
        href_nx  = (state_nx == ST_ACTIVE) && (x_nx < X_ACT);
        clken_nx = href_nx && (div_nx == 4'd0);
        done_nx  = (state_nx == ST_VFRONT) && (div_nx == DIV_LAST) &&
                   (x_nx == X_LAST) && (line_nx == V_FRONT - 11'd1);
        case (pat_q)
            2'd0:    pix_nx = x_nx[7:0];
            2'd1:    pix_nx = line_nx[7:0];
            2'd2:    pix_nx = (x_nx[3] ^ line_nx[3]) ? 8'hFF : 8'h00;
            default: pix_nx = frame_cnt[7:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            div_cnt          <= 4'd0;
            x_cnt            <= 12'd0;
            line_cnt         <= 11'd0;
            pat_q            <= 2'd0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Y       <= 8'd0;
            frame_done       <= 1'b0;
            frame_cnt        <= 16'd0;
        end else begin
            state            <= state_nx;
            div_cnt          <= div_nx;
            x_cnt            <= x_nx;
            line_cnt         <= line_nx;
            post_frame_vsync <= vsync_nx;
            post_frame_href  <= href_nx;
            post_frame_clken <= clken_nx;
            frame_done       <= done_nx;
            // Pattern is frozen for the whole frame once vsync starts.
            if (state_nx == ST_VSYNC && state != ST_VSYNC) pat_q <= pattern_sel;
            if (clken_nx) post_img_Y <= pix_nx;
            if (done_nx) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_vip_frame_stream_gen.sv
// Bench for vip_frame_stream_gen: three instances (DIV=1 8x4, DIV=3 8x4, DIV=1 16x16)
// share clock, reset and inputs; a frame-level arithmetic model predicts every output.
module tb_vip_frame_stream_gen;

    localparam int NI = 3;
    localparam int HD [NI] = '{8, 8, 16};
    localparam int VD [NI] = '{4, 4, 16};
    localparam int DV [NI] = '{1, 3, 1};
    localparam int HB = 4;
    localparam int VS = 1;
    localparam int VB = 1;
    localparam int VF = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic [1:0] pattern_sel = 2'd0;

    logic [NI-1:0]        vs_o, hr_o, ck_o, fd_o;
    logic [NI-1:0][7:0]   y_o;
    logic [NI-1:0][15:0]  fc_o;

    int n_cmp = 0;
    int n_bad = 0;

    int m_run [NI];
    int m_k   [NI];
    int m_pat [NI];
    int m_fc  [NI];
    int m_yh  [NI];
    int ck_cnt[NI];

    always #5 clk = ~clk;

    vip_frame_stream_gen #(.IMG_HDISP(11'd8), .IMG_VDISP(11'd4), .H_BLANK(11'd4),
        .V_SYNC(11'd1), .V_BACK(11'd1), .V_FRONT(11'd1), .CLKEN_DIV(4'd1)) u_gen0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .post_frame_vsync(vs_o[0]), .post_frame_href(hr_o[0]), .post_frame_clken(ck_o[0]),
        .post_img_Y(y_o[0]), .frame_done(fd_o[0]), .frame_cnt(fc_o[0]));

    vip_frame_stream_gen #(.IMG_HDISP(11'd8), .IMG_VDISP(11'd4), .H_BLANK(11'd4),
        .V_SYNC(11'd1), .V_BACK(11'd1), .V_FRONT(11'd1), .CLKEN_DIV(4'd3)) u_gen1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .post_frame_vsync(vs_o[1]), .post_frame_href(hr_o[1]), .post_frame_clken(ck_o[1]),
        .post_img_Y(y_o[1]), .frame_done(fd_o[1]), .frame_cnt(fc_o[1]));

    vip_frame_stream_gen #(.IMG_HDISP(11'd16), .IMG_VDISP(11'd16), .H_BLANK(11'd4),
        .V_SYNC(11'd1), .V_BACK(11'd1), .V_FRONT(11'd1), .CLKEN_DIV(4'd1)) u_gen2 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .pattern_sel(pattern_sel),
        .post_frame_vsync(vs_o[2]), .post_frame_href(hr_o[2]), .post_frame_clken(ck_o[2]),
        .post_img_Y(y_o[2]), .frame_done(fd_o[2]), .frame_cnt(fc_o[2]));

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int frame_len(input int i);
        return (VS + VB + VD[i] + VF) * (HD[i] + HB) * DV[i];
    endfunction

    // Expected {vsync, href, clken, frame_done, Y} at cycle k of a running frame.
    function automatic logic [11:0] model_out(input int i, input int k, input int pat,
                                              input int fc, input int yh);
        int lc, line, r, slot, ph, row;
        logic vs, hr, ck, fd;
        logic [7:0] y, xb, rb, fb;
        lc   = (HD[i] + HB) * DV[i];
        line = k / lc;
        r    = k % lc;
        slot = r / DV[i];
        ph   = r % DV[i];
        row  = line - VS - VB;
        vs   = (line < VS);
        hr   = (row >= 0) && (row < VD[i]) && (slot < HD[i]);
        ck   = hr && (ph == 0);
        fd   = (k == frame_len(i) - 1);
        xb   = slot[7:0];
        rb   = row[7:0];
        fb   = fc[7:0];
        y    = yh[7:0];
        if (ck) begin
            case (pat)
                0:       y = xb;
                1:       y = rb;
                2:       y = (xb[3] ^ rb[3]) ? 8'hFF : 8'h00;
                default: y = fb;
            endcase
        end
        return {vs, hr, ck, fd, y};
    endfunction

    // Frame-level model state: running flag, cycle index in frame, pattern, frame count.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < NI; i++) begin
            if (!rst_n) begin
                m_run[i] = 0; m_k[i] = 0; m_pat[i] = 0; m_fc[i] = 0;
            end else if (m_run[i] == 0) begin
                if (enable) begin
                    m_run[i] = 1; m_k[i] = 0; m_pat[i] = int'(pattern_sel);
                end
            end else begin
                m_k[i]++;
                if (m_k[i] == frame_len(i) - 1) m_fc[i] = (m_fc[i] + 1) & 16'hFFFF;
                if (m_k[i] == frame_len(i)) begin
                    if (enable) begin
                        m_k[i] = 0; m_pat[i] = int'(pattern_sel);
                    end else begin
                        m_run[i] = 0; m_k[i] = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            logic [11:0] e;
            if (!rst_n) begin
                m_yh[i]   = 0;
                ck_cnt[i] = 0;
            end else begin
                if (m_run[i] != 0) e = model_out(i, m_k[i], m_pat[i], m_fc[i], m_yh[i]);
                else               e = {4'b0000, 8'(m_yh[i])};
                m_yh[i] = int'(e[7:0]);
                check_val($sformatf("u%0d_vsync", i), int'(vs_o[i]), int'(e[11]));
                check_val($sformatf("u%0d_href", i),  int'(hr_o[i]), int'(e[10]));
                check_val($sformatf("u%0d_clken", i), int'(ck_o[i]), int'(e[9]));
                check_val($sformatf("u%0d_done", i),  int'(fd_o[i]), int'(e[8]));
                check_val($sformatf("u%0d_Y", i),     int'(y_o[i]),  int'(e[7:0]));
                check_val($sformatf("u%0d_fcnt", i),  int'(fc_o[i]), m_fc[i]);
                if (ck_o[i]) ck_cnt[i]++;
                if (fd_o[i]) begin
                    check_val($sformatf("u%0d_clken_per_frame", i), ck_cnt[i], HD[i] * VD[i]);
                    ck_cnt[i] = 0;
                end
            end
        end
    end

    initial begin
        bit seen;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d_rst_vsync", i), int'(vs_o[i]), 0);
            check_val($sformatf("u%0d_rst_clken", i), int'(ck_o[i]), 0);
            check_val($sformatf("u%0d_rst_Y", i), int'(y_o[i]), 0);
            check_val($sformatf("u%0d_rst_fcnt", i), int'(fc_o[i]), 0);
        end
        @(posedge clk); #3 rst_n = 1'b1;

        // Flat pattern over several frames, then a mid-frame pattern change.
        @(negedge clk); #1;
        pattern_sel = 2'd3;
        enable = 1'b1;
        repeat (760) @(negedge clk);
        #1 pattern_sel = 2'd1;
        repeat (300) @(negedge clk);
        #1 pattern_sel = 2'd0;
        repeat (500) @(negedge clk);

        // Random pattern and enable phases, including drops mid-frame.
        for (int p = 0; p < 12; p++) begin
            #1;
            pattern_sel = 2'($urandom_range(0, 3));
            enable = ($urandom_range(0, 3) != 0);
            repeat ($urandom_range(30, 400)) @(negedge clk);
        end

        // Reset pulsed in the middle of an active line.
        #1 enable = 1'b1;
        pattern_sel = 2'd2;
        seen = 0;
        for (int c = 0; c < 1000 && !seen; c++) begin
            @(negedge clk);
            if (hr_o[0] && m_k[0] > 3 * (HD[0] + HB)) seen = 1;
        end
        check_val("wait_active_line", int'(seen), 1);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d_async_rst_out", i),
                      int'({vs_o[i], hr_o[i], ck_o[i], fd_o[i]}), 0);
            check_val($sformatf("u%0d_async_rst_Y", i), int'(y_o[i]), 0);
            check_val($sformatf("u%0d_async_rst_fcnt", i), int'(fc_o[i]), 0);
        end
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (800) @(negedge clk);

        // Drop enable and let every instance finish and fall idle.
        #1 enable = 1'b0;
        repeat (900) @(negedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            check_val($sformatf("u%0d_idle_out", i), int'({vs_o[i], hr_o[i], ck_o[i]}), 0);
            check_val($sformatf("u%0d_idle_fcnt", i), int'(fc_o[i]), m_fc[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
